// File: rtl/gfx_vram_arbiter.sv
// VRAM port arbiter for BG fetch, OBJ fetch and CPU access.
// Scanline-phase priority, a CPU starvation guard, and read-data return tagging.
module gfx_vram_arbiter #(
    parameter int unsigned ADDR_W       = 17,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned CPU_MAX_WAIT = 8
) (
    input  logic              clock,
    input  logic              rst_b,
    input  logic              hblank,
    input  logic              bg_req,
    input  logic [ADDR_W-1:0] bg_addr,
    output logic              bg_gnt,
    output logic              bg_rvalid,
    input  logic              obj_req,
    input  logic [ADDR_W-1:0] obj_addr,
    output logic              obj_gnt,
    output logic              obj_rvalid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned WAIT_W = $clog2(CPU_MAX_WAIT + 1);
    localparam int unsigned PIPE_W = 2 * RD_LAT;

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_BG   = 2'd1;
    localparam logic [1:0] TAG_OBJ  = 2'd2;
    localparam logic [1:0] TAG_CPU  = 2'd3;

    logic [WAIT_W-1:0] cpu_wait_q;
    logic [WAIT_W-1:0] cpu_wait_d;
    logic [PIPE_W-1:0] tag_q;
    logic [1:0]        tag_in;
    logic [1:0]        tag_out;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              cpu_force;

    assign cpu_force = rst_b && cpu_req && (cpu_wait_q == WAIT_W'(CPU_MAX_WAIT));

    // Grant selection; reset masks grants immediately.
    always_comb begin
        bg_gnt  = 1'b0;
        obj_gnt = 1'b0;
        cpu_gnt = 1'b0;
        if (rst_b) begin
            if (cpu_force) begin
                cpu_gnt = 1'b1;
            end else if (!hblank) begin
                if (bg_req)       bg_gnt  = 1'b1;
                else if (obj_req) obj_gnt = 1'b1;
                else if (cpu_req) cpu_gnt = 1'b1;
            end else begin
                if (obj_req)      obj_gnt = 1'b1;
                else if (cpu_req) cpu_gnt = 1'b1;
                else if (bg_req)  bg_gnt  = 1'b1;
            end
        end
    end

    // VRAM command mux; address and write data hold their last value when idle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        tag_in    = TAG_NONE;
        if (bg_gnt) begin
            mem_en   = 1'b1;
            mem_be   = 4'hF;
            mem_addr = bg_addr;
            tag_in   = TAG_BG;
        end else if (obj_gnt) begin
            mem_en   = 1'b1;
            mem_be   = 4'hF;
            mem_addr = obj_addr;
            tag_in   = TAG_OBJ;
        end else if (cpu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_be    = cpu_be;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            tag_in    = cpu_we ? TAG_NONE : TAG_CPU;
        end
    end

    // CPU wait counter saturates so the force condition stays asserted.
    always_comb begin
        cpu_wait_d = cpu_wait_q;
        if (!cpu_req || cpu_gnt) begin
            cpu_wait_d = '0;
        end else if (cpu_wait_q != WAIT_W'(CPU_MAX_WAIT)) begin
            cpu_wait_d = cpu_wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge rst_b) begin
        if (!rst_b) begin
            cpu_wait_q <= '0;
            tag_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            cpu_wait_q <= cpu_wait_d;
            tag_q      <= PIPE_W'({tag_q, tag_in});
            addr_q     <= mem_addr;
            wdata_q    <= mem_wdata;
        end
    end

    assign tag_out    = tag_q[PIPE_W-1 -: 2];
    assign bg_rvalid  = rst_b && (tag_out == TAG_BG);
    assign obj_rvalid = rst_b && (tag_out == TAG_OBJ);
    assign cpu_rvalid = rst_b && (tag_out == TAG_CPU);
    assign rdata      = mem_rdata;

endmodule

// File: tb/tb_gfx_vram_arbiter.sv
// Bench for gfx_vram_arbiter: two instances (read latency 1 and 3) share stimulus
// and are checked every cycle against a cycle-level reference model.
module tb_gfx_vram_arbiter;

    localparam int CPU_MAX = 8;

    logic clock = 1'b0;
    logic rst_b;
    logic hblank;
    logic bg_req, obj_req, cpu_req, cpu_we;
    logic [16:0] bg_addr, obj_addr, cpu_addr;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_wdata, mem_rdata;

    logic [1:0]  bg_gnt, bg_rvalid, obj_gnt, obj_rvalid, cpu_gnt, cpu_rvalid;
    logic [1:0]  mem_en, mem_we;
    logic [3:0]  mem_be [2];
    logic [16:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] rdata [2];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        gfx_vram_arbiter #(
            .ADDR_W(17), .DATA_W(32), .RD_LAT(g == 0 ? 1 : 3), .CPU_MAX_WAIT(CPU_MAX)
        ) u_dut (
            .clock(clock), .rst_b(rst_b), .hblank(hblank),
            .bg_req(bg_req), .bg_addr(bg_addr), .bg_gnt(bg_gnt[g]), .bg_rvalid(bg_rvalid[g]),
            .obj_req(obj_req), .obj_addr(obj_addr), .obj_gnt(obj_gnt[g]), .obj_rvalid(obj_rvalid[g]),
            .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
            .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt[g]), .cpu_rvalid(cpu_rvalid[g]),
            .rdata(rdata[g]), .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_be(mem_be[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata)
        );
    end

    int checks = 0;
    int errors = 0;

    // Reference model state: source (0 none, 1 BG, 2 OBJ, 3 CPU) due back at each cycle.
    int          exp_src [2][0:2047];
    int          m_cyc;
    int          m_wait;
    logic [16:0] m_addr;
    logic [31:0] m_wdata;
    int          e_win;
    logic [2:0]  obs_gnt [2];
    logic [2:0]  obs_rv  [2];

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [2:0] onehot(input int src);
        case (src)
            1:       return 3'b100;
            2:       return 3'b010;
            3:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic req_of(input int src);
        case (src)
            1:       return bg_req;
            2:       return obj_req;
            default: return cpu_req;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, m_cyc);
        end
    endtask

    // One clock cycle: inputs are already driven; check mid-cycle, then advance the model.
    task automatic cyc();
        int          order [3];
        int          src;
        logic        e_we;
        logic [3:0]  e_be;
        logic [16:0] e_addr;
        logic [31:0] e_wdata;
        #4;
        e_win = 0;
        if (!rst_b) begin
            m_wait  = 0;
            m_addr  = '0;
            m_wdata = '0;
            for (int i = 0; i < 2; i++)
                for (int k = 0; k < 4; k++) exp_src[i][m_cyc + k] = 0;
        end else if (cpu_req && m_wait == CPU_MAX) begin
            e_win = 3;
        end else begin
            if (hblank) order = '{2, 3, 1};
            else        order = '{1, 2, 3};
            for (int k = 0; k < 3; k++)
                if (e_win == 0 && req_of(order[k])) e_win = order[k];
        end
        e_we    = (e_win == 3) && cpu_we;
        e_be    = (e_win == 0) ? 4'h0 : ((e_win == 3) ? cpu_be : 4'hF);
        e_addr  = (e_win == 1) ? bg_addr : (e_win == 2) ? obj_addr :
                  (e_win == 3) ? cpu_addr : m_addr;
        e_wdata = (e_win == 3) ? cpu_wdata : m_wdata;
        for (int i = 0; i < 2; i++) begin
            obs_gnt[i] = {bg_gnt[i], obj_gnt[i], cpu_gnt[i]};
            obs_rv[i]  = {bg_rvalid[i], obj_rvalid[i], cpu_rvalid[i]};
            chk($sformatf("gnt[%0d]", i), 64'(obs_gnt[i]), 64'(onehot(e_win)));
            chk($sformatf("mem_en[%0d]", i), 64'(mem_en[i]), 64'(e_win != 0));
            chk($sformatf("mem_we[%0d]", i), 64'(mem_we[i]), 64'(e_we));
            chk($sformatf("mem_be[%0d]", i), 64'(mem_be[i]), 64'(e_be));
            chk($sformatf("mem_addr[%0d]", i), 64'(mem_addr[i]), 64'(e_addr));
            chk($sformatf("mem_wdata[%0d]", i), 64'(mem_wdata[i]), 64'(e_wdata));
            src = rst_b ? exp_src[i][m_cyc] : 0;
            chk($sformatf("rvalid[%0d]", i), 64'(obs_rv[i]), 64'(onehot(src)));
            if (src != 0) chk($sformatf("rdata[%0d]", i), 64'(rdata[i]), 64'(mem_rdata));
        end
        @(posedge clock);
        if (rst_b) begin
            if (e_win != 0 && !e_we)
                for (int i = 0; i < 2; i++) exp_src[i][m_cyc + lat(i)] = e_win;
            m_addr  = e_addr;
            m_wdata = e_wdata;
            if (!cpu_req || e_win == 3) m_wait = 0;
            else if (m_wait < CPU_MAX)  m_wait = m_wait + 1;
        end
        m_cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        bg_req = 0; obj_req = 0; cpu_req = 0; cpu_we = 0;
        for (int k = 0; k < n; k++) begin
            mem_rdata = $urandom;
            cyc();
        end
    endtask

    initial begin
        int first_cpu;
        int seen;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 2048; k++) exp_src[i][k] = 0;
        m_cyc = 0; m_wait = 0; m_addr = '0; m_wdata = '0;
        rst_b = 0; hblank = 0;
        bg_req = 1; obj_req = 1; cpu_req = 1; cpu_we = 0; cpu_be = 4'hF;
        bg_addr = 17'h00010; obj_addr = 17'h00020; cpu_addr = 17'h00030;
        cpu_wdata = 32'h0; mem_rdata = 32'h0;
        #1;

        // Reset with all requests active
        cyc();
        chk("rst_gnt", 64'(obs_gnt[0]), 64'(3'b000));
        chk("rst_rvalid", 64'(obs_rv[1]), 64'(3'b000));
        cyc();

        // Release: BG wins in hdraw, returns after one cycle on the latency-1 instance
        rst_b = 1; obj_req = 0; cpu_req = 0; mem_rdata = 32'h1234_5678;
        cyc();
        chk("rel_bg_gnt", 64'(obs_gnt[0]), 64'(3'b100));
        bg_req = 0; mem_rdata = 32'hCAFE_0001;
        cyc();
        chk("rel_bg_rvalid", 64'(obs_rv[0]), 64'(3'b100));
        idle(4);

        // Hdraw contention
        bg_req = 1; obj_req = 1;
        for (int k = 0; k < 3; k++) begin
            bg_addr = 17'($urandom); mem_rdata = $urandom;
            cyc();
            chk("hdraw_bg", 64'(obs_gnt[0]), 64'(3'b100));
        end
        bg_req = 0;
        cyc();
        chk("hdraw_obj", 64'(obs_gnt[0]), 64'(3'b010));
        idle(4);

        // Hblank priority
        hblank = 1; bg_req = 1; obj_req = 1; cpu_req = 1;
        cyc();
        chk("hb_obj", 64'(obs_gnt[0]), 64'(3'b010));
        obj_req = 0;
        cyc();
        chk("hb_cpu", 64'(obs_gnt[0]), 64'(3'b001));
        cpu_req = 0;
        cyc();
        chk("hb_bg", 64'(obs_gnt[0]), 64'(3'b100));
        hblank = 0;
        idle(4);

        // Starvation guard: CPU forced in at cycle 8, then again 9 cycles later
        bg_req = 1; cpu_req = 1; cpu_we = 0; first_cpu = -1;
        for (int k = 0; k < 20; k++) begin
            mem_rdata = $urandom;
            cyc();
            if (obs_gnt[0][0] && first_cpu < 0) first_cpu = k;
        end
        chk("starve_first", 64'(first_cpu), 64'(8));
        idle(4);

        // CPU write
        cpu_req = 1; cpu_we = 1; cpu_be = 4'b0011; cpu_addr = 17'h00100; cpu_wdata = 32'hDEADBEEF;
        cyc();
        chk("wr_gnt", 64'(obs_gnt[0]), 64'(3'b001));
        seen = 0;
        cpu_req = 0; cpu_we = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            seen += int'(obs_rv[0][0]) + int'(obs_rv[1][0]);
        end
        chk("wr_no_rvalid", 64'(seen), 64'(0));

        // Reset while an OBJ read is in flight on the latency-3 instance
        hblank = 1; obj_req = 1; obj_addr = 17'h1ABCD;
        cyc();
        chk("mid_obj_gnt", 64'(obs_gnt[1]), 64'(3'b010));
        obj_req = 0;
        cyc();
        rst_b = 0;
        cyc();
        rst_b = 1; seen = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            seen += int'(obs_rv[1][1]);
        end
        chk("mid_no_obj_rvalid", 64'(seen), 64'(0));
        hblank = 0;

        // Randomized traffic honouring the hold-until-grant handshake
        for (int k = 0; k < 500; k++) begin
            if (!(bg_req && e_win != 1)) begin
                bg_req = 1'($urandom_range(0, 1)); bg_addr = 17'($urandom);
            end
            if (!(obj_req && e_win != 2)) begin
                obj_req = 1'($urandom_range(0, 1)); obj_addr = 17'($urandom);
            end
            if (!(cpu_req && e_win != 3)) begin
                cpu_req = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom_range(0, 1));
                cpu_be = 4'($urandom); cpu_addr = 17'($urandom); cpu_wdata = $urandom;
            end
            hblank    = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            rst_b     = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            cyc();
        end
        rst_b = 1;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
